// File: rtl/miriscv_ram_arb_pkg.sv
// Shared types and constants for the arbiter that splits the unified RAM
// between the fetch port and the load/store port.
package miriscv_ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACK_I, ACK_D} state_e;
    typedef enum logic {GNT_I, GNT_D} grant_e;

    localparam int ADDR_LSB = 2;

    // An access is legal only if it is word aligned and lands inside the RAM.
    function automatic logic addr_in_range(logic [31:0] addr, int aw);
        return ((addr >> (aw + ADDR_LSB)) == 32'd0) && (addr[ADDR_LSB-1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-way round-robin picker: a tie goes to whichever side was not served last.
module miriscv_rr_arb2
    import miriscv_ram_arb_pkg::*;
(
    input  logic instr_req_i,
    input  logic data_req_i,
    input  logic last_grant_i,
    output logic gnt_instr_o,
    output logic gnt_data_o
);

    always_comb begin
        gnt_instr_o = 1'b0;
        gnt_data_o  = 1'b0;
        if (instr_req_i && data_req_i) begin
            if (last_grant_i == GNT_D) begin
                gnt_instr_o = 1'b1;
            end else begin
                gnt_data_o = 1'b1;
            end
        end else begin
            gnt_instr_o = instr_req_i;
            gnt_data_o  = data_req_i;
        end
    end

endmodule

// File: rtl/miriscv_ram_arbiter.sv
// Shares the single-port program/data RAM between instruction fetch and
// load/store; one access every two cycles, read data returned with the ack.
module miriscv_ram_arbiter
    import miriscv_ram_arb_pkg::*;
#(
    parameter  int RAM_SIZE = 512,
    localparam int AW       = $clog2(RAM_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_ack_o,
    output logic [31:0]   instr_rdata_o,

    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_ack_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,

    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_be_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);

    state_e state_q, state_d;
    grant_e lastGrant_q, lastGrant_d;
    logic   err_q, err_d;
    logic   store_q, store_d;

    logic   gntInstr, gntData;
    logic   instrInRange, dataInRange;

    assign instrInRange = addr_in_range(instr_addr_i, AW);
    assign dataInRange  = addr_in_range(data_addr_i, AW);

    miriscv_rr_arb2 u_rr_arb2 (
        .instr_req_i  (instr_req_i),
        .data_req_i   (data_req_i),
        .last_grant_i (lastGrant_q),
        .gnt_instr_o  (gntInstr),
        .gnt_data_o   (gntData)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            lastGrant_q <= GNT_D;
            err_q       <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            err_q       <= err_d;
            store_q     <= store_d;
        end
    end

    // err_q/store_q remember what the granted access was so the ack cycle
    // knows whether to forward the RAM read data or return zero.
    always_comb begin
        state_d       = state_q;
        lastGrant_d   = lastGrant_q;
        err_d         = err_q;
        store_d       = store_q;
        instr_ack_o   = 1'b0;
        instr_rdata_o = 32'h0;
        data_ack_o    = 1'b0;
        data_rdata_o  = 32'h0;
        data_err_o    = 1'b0;
        ram_en_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_be_o      = 4'h0;
        ram_addr_o    = '0;
        ram_wdata_o   = 32'h0;

        case (state_q)
            IDLE: begin
                if (gntInstr) begin
                    state_d     = ACK_I;
                    lastGrant_d = GNT_I;
                    err_d       = !instrInRange;
                    store_d     = 1'b0;
                    ram_en_o    = instrInRange;
                    ram_addr_o  = instr_addr_i[AW+ADDR_LSB-1:ADDR_LSB];
                end else if (gntData) begin
                    state_d     = ACK_D;
                    lastGrant_d = GNT_D;
                    err_d       = !dataInRange;
                    store_d     = data_we_i;
                    ram_en_o    = dataInRange;
                    ram_we_o    = data_we_i && dataInRange;
                    ram_be_o    = data_be_i;
                    ram_addr_o  = data_addr_i[AW+ADDR_LSB-1:ADDR_LSB];
                    ram_wdata_o = data_wdata_i;
                end
            end
            ACK_I: begin
                state_d       = IDLE;
                instr_ack_o   = 1'b1;
                instr_rdata_o = err_q ? 32'h0 : ram_rdata_i;
            end
            ACK_D: begin
                state_d      = IDLE;
                data_ack_o   = 1'b1;
                data_err_o   = err_q;
                data_rdata_o = (err_q || store_q) ? 32'h0 : ram_rdata_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences every output at once, before any clock edge.
        if (rst_i) begin
            instr_ack_o   = 1'b0;
            instr_rdata_o = 32'h0;
            data_ack_o    = 1'b0;
            data_rdata_o  = 32'h0;
            data_err_o    = 1'b0;
            ram_en_o      = 1'b0;
            ram_we_o      = 1'b0;
            ram_be_o      = 4'h0;
            ram_addr_o    = '0;
            ram_wdata_o   = 32'h0;
        end
    end

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Self-checking bench for miriscv_ram_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model with its own RAM image.
module tb_miriscv_ram_arbiter;

    localparam int RAM_SIZE = 512;
    localparam int AW       = $clog2(RAM_SIZE);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_ack_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [31:0]   data_addr_i;
    logic [31:0]   data_wdata_i;
    logic          data_ack_o;
    logic [31:0]   data_rdata_o;
    logic          data_err_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ramRdata = 32'h0;

    logic [31:0]   ramMem [RAM_SIZE];
    logic [31:0]   refMem [RAM_SIZE];

    int checks = 0;
    int fails  = 0;

    miriscv_ram_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_ack_o   (instr_ack_o),
        .instr_rdata_o (instr_rdata_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_ack_o    (data_ack_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .ram_en_o      (ram_en_o),
        .ram_we_o      (ram_we_o),
        .ram_be_o      (ram_be_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ramRdata)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(int i);
        if (i == 4)  return 32'h0050_0093;
        if (i == 65) return 32'h0;
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Behavioural single-port RAM with a registered read port.
    initial begin
        for (int i = 0; i < RAM_SIZE; i++) ramMem[i] = init_word(i);
        forever begin
            @(posedge clk_i);
            if (ram_en_o === 1'b1) begin
                ramRdata <= ramMem[ram_addr_o];
                if (ram_we_o === 1'b1)
                    for (int b = 0; b < 4; b++)
                        if (ram_be_o[b]) ramMem[ram_addr_o][8*b +: 8] = ram_wdata_o[8*b +: 8];
            end
        end
    end

    function automatic bit legal(logic [31:0] addr);
        return (addr < 32'(RAM_SIZE * 4)) && (addr % 4 == 0);
    endfunction

    task automatic model_store(input int word, input logic [3:0] be, input logic [31:0] wdata);
        for (int b = 0; b < 4; b++)
            if (be[b]) refMem[word][8*b +: 8] = wdata[8*b +: 8];
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return 32'h800 + 32'($urandom_range(0, 15)) * 4;
            1:       return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            2:       return 32'h8000_0000 | (32'($urandom_range(0, 15)) * 4);
            default: return 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    task automatic quiet_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        quiet_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One complete access on one port with nothing competing.
    task automatic do_access(input bit isData, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input string tag, output logic [31:0] obsRdata);
        bit          inRange;
        int          word;
        logic [31:0] expRd;
        inRange = legal(addr);
        word    = int'(addr / 4);
        @(negedge clk_i);
        if (isData) begin
            data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
        end else begin
            instr_req_i = 1'b1; instr_addr_i = addr;
        end
        #1;
        checks++; if (ram_en_o !== inRange) begin fails++; $display("[TB] FAIL %s grant_en: got %b, expected %b", tag, ram_en_o, inRange); end
        if (inRange) begin
            checks++; if (ram_addr_o !== word[AW-1:0]) begin fails++; $display("[TB] FAIL %s grant_addr: got %0d, expected %0d", tag, ram_addr_o, word); end
            checks++; if (ram_we_o !== (isData && we)) begin fails++; $display("[TB] FAIL %s grant_we: got %b, expected %b", tag, ram_we_o, isData && we); end
            checks++; if (ram_be_o !== (isData ? be : 4'h0)) begin fails++; $display("[TB] FAIL %s grant_be: got %h, expected %h", tag, ram_be_o, isData ? be : 4'h0); end
            if (isData && we) begin
                checks++; if (ram_wdata_o !== wdata) begin fails++; $display("[TB] FAIL %s grant_wdata: got %h, expected %h", tag, ram_wdata_o, wdata); end
            end
        end
        checks++; if ({instr_ack_o, data_ack_o} !== 2'b00) begin fails++; $display("[TB] FAIL %s early_ack: got %b, expected 00", tag, {instr_ack_o, data_ack_o}); end
        expRd = (inRange && !(isData && we)) ? refMem[word] : 32'h0;
        @(negedge clk_i);
        #1;
        checks++; if ({instr_ack_o, data_ack_o} !== (isData ? 2'b01 : 2'b10)) begin fails++; $display("[TB] FAIL %s ack: got %b, expected %b", tag, {instr_ack_o, data_ack_o}, isData ? 2'b01 : 2'b10); end
        obsRdata = isData ? data_rdata_o : instr_rdata_o;
        checks++; if (obsRdata !== expRd) begin fails++; $display("[TB] FAIL %s rdata: got %h, expected %h", tag, obsRdata, expRd); end
        checks++; if (data_err_o !== (isData && !inRange)) begin fails++; $display("[TB] FAIL %s err: got %b, expected %b", tag, data_err_o, isData && !inRange); end
        checks++; if (ram_en_o !== 1'b0) begin fails++; $display("[TB] FAIL %s ack_en: got %b, expected 0", tag, ram_en_o); end
        if (inRange && isData && we) model_store(word, be, wdata);
        quiet_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h20; data_wdata_i = $urandom;
        #1;
        checks++; if ({ram_en_o, ram_we_o, instr_ack_o, data_ack_o, data_err_o} !== 5'b0) begin fails++; $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {ram_en_o, ram_we_o, instr_ack_o, data_ack_o, data_err_o}); end
        checks++; if ({ram_addr_o, ram_be_o, ram_wdata_o, instr_rdata_o, data_rdata_o} !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h %h %h %h %h, expected all 0", ram_addr_o, ram_be_o, ram_wdata_o, instr_rdata_o, data_rdata_o); end
        @(negedge clk_i);
        quiet_inputs();
        rst_i = 1'b0;
        #1;
        checks++; if ({ram_en_o, instr_ack_o, data_ack_o} !== 3'b0) begin fails++; $display("[TB] FAIL reset_idle: got %b, expected 000", {ram_en_o, instr_ack_o, data_ack_o}); end
    endtask

    task automatic test_single_fetch();
        logic [31:0] rd;
        do_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, "fetch", rd);
        checks++; if (rd !== 32'h0050_0093) begin fails++; $display("[TB] FAIL fetch_word: got %h, expected 00500093", rd); end
    endtask

    task automatic test_byte_store_load();
        logic [31:0] rd;
        do_access(1'b1, 1'b1, 4'b0010, 32'h104, 32'h0000_AB00, "store_byte", rd);
        checks++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL store_rdata: got %h, expected 0", rd); end
        do_access(1'b1, 1'b0, 4'h0, 32'h104, 32'h0, "load_byte", rd);
        checks++; if (rd !== 32'h0000_AB00) begin fails++; $display("[TB] FAIL load_after_store: got %h, expected 0000ab00", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        do_access(1'b1, 1'b0, 4'h0, 32'h800, 32'h0, "oor_load", rd);
        do_access(1'b1, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, "oor_store", rd);
        do_access(1'b0, 1'b0, 4'h0, 32'h2, 32'h0, "misaligned_fetch", rd);
        do_access(1'b1, 1'b0, 4'h0, 32'h13, 32'h0, "misaligned_load", rd);
        do_access(1'b0, 1'b0, 4'h0, 32'h7FC, 32'h0, "last_word_fetch", rd);
    endtask

    task automatic test_contention();
        @(negedge clk_i);
        rst_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h20;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bit          expD;
            logic [31:0] expRd;
            expD  = ((k - 1) / 2) % 2 == 1;
            expRd = refMem[expD ? 8 : 4];
            if (k > 1) @(negedge clk_i);
            #1;
            checks++; if ((instr_ack_o && data_ack_o) !== 1'b0) begin fails++; $display("[TB] FAIL contention_double_ack c%0d: got 1, expected 0", k); end
            if (k % 2 == 1) begin
                checks++; if ({ram_en_o, instr_ack_o, data_ack_o} !== 3'b100) begin fails++; $display("[TB] FAIL contention_grant c%0d: got %b, expected 100", k, {ram_en_o, instr_ack_o, data_ack_o}); end
                checks++; if (ram_addr_o !== (expD ? 9'd8 : 9'd4)) begin fails++; $display("[TB] FAIL contention_addr c%0d: got %0d, expected %0d", k, ram_addr_o, expD ? 8 : 4); end
            end else begin
                checks++; if ({instr_ack_o, data_ack_o} !== (expD ? 2'b01 : 2'b10)) begin fails++; $display("[TB] FAIL contention_ack c%0d: got %b, expected %b", k, {instr_ack_o, data_ack_o}, expD ? 2'b01 : 2'b10); end
                checks++; if ((expD ? data_rdata_o : instr_rdata_o) !== expRd) begin fails++; $display("[TB] FAIL contention_rdata c%0d: got %h, expected %h", k, expD ? data_rdata_o : instr_rdata_o, expRd); end
            end
        end
        quiet_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd, rd;
        wd = $urandom;
        // Store granted, then reset lands in its ack cycle.
        @(negedge clk_i);
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h28; data_wdata_i = wd;
        #1;
        checks++; if ({ram_en_o, ram_we_o} !== 2'b11) begin fails++; $display("[TB] FAIL midrst_store_grant: got %b, expected 11", {ram_en_o, ram_we_o}); end
        model_store(10, 4'hF, wd);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if ({data_ack_o, data_err_o, ram_en_o} !== 3'b000) begin fails++; $display("[TB] FAIL midrst_data_ack: got %b, expected 000", {data_ack_o, data_err_o, ram_en_o}); end
        @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        data_we_i = 1'b0; data_addr_i = 32'h24;
        #1;
        checks++; if (data_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL midrst_data_ack_held: got %b, expected 0", data_ack_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++; if (ram_addr_o !== 9'd4 || ram_en_o !== 1'b1) begin fails++; $display("[TB] FAIL midrst_tie_instr: got en %b addr %0d, expected en 1 addr 4", ram_en_o, ram_addr_o); end
        @(negedge clk_i);
        #1;
        checks++; if ({instr_ack_o, data_ack_o} !== 2'b10) begin fails++; $display("[TB] FAIL midrst_tie_ack: got %b, expected 10", {instr_ack_o, data_ack_o}); end
        quiet_inputs();
        // Fetch granted and lost to reset; last grant must return to DATA.
        @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h30;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if (instr_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL midrst_instr_ack: got %b, expected 0", instr_ack_o); end
        data_req_i = 1'b1; data_addr_i = 32'h24;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++; if (ram_addr_o !== 9'd12) begin fails++; $display("[TB] FAIL midrst_lastgrant: got addr %0d, expected 12", ram_addr_o); end
        @(negedge clk_i);
        quiet_inputs();
        do_access(1'b1, 1'b0, 4'h0, 32'h28, 32'h0, "committed_store", rd);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            quiet_inputs();
            #1;
            checks++;
            if ({ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, instr_ack_o, data_ack_o, data_err_o} !== '0) begin
                fails++; $display("[TB] FAIL idle_c%0d: got en %b we %b ack %b%b err %b, expected all 0", c, ram_en_o, ram_we_o, instr_ack_o, data_ack_o, data_err_o);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        bit          iPend = 0, dPend = 0, busy = 0, lastD = 1, winD = 0;
        bit          expErr = 0, inRange;
        logic [31:0] iAddr = 0, dAddr = 0, dWdata = 0, expRd = 0, addr;
        logic        dWe = 0;
        logic [3:0]  dBe = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            if (!iPend && $urandom_range(0, 1) == 1) begin iPend = 1; iAddr = rand_addr(); end
            if (!dPend && $urandom_range(0, 1) == 1) begin
                dPend = 1; dAddr = rand_addr(); dWe = 1'($urandom_range(0, 1)); dBe = 4'($urandom); dWdata = $urandom;
            end
            instr_req_i = iPend; instr_addr_i = iAddr;
            data_req_i = dPend; data_addr_i = dAddr; data_we_i = dWe; data_be_i = dBe; data_wdata_i = dWdata;
            #1;
            if (busy) begin
                checks++; if ({instr_ack_o, data_ack_o} !== (winD ? 2'b01 : 2'b10)) begin fails++; $display("[TB] FAIL rnd_ack c%0d: got %b, expected %b", c, {instr_ack_o, data_ack_o}, winD ? 2'b01 : 2'b10); end
                checks++; if ({instr_rdata_o, data_rdata_o} !== (winD ? {32'h0, expRd} : {expRd, 32'h0})) begin fails++; $display("[TB] FAIL rnd_rdata c%0d: got %h/%h, expected %h on %s", c, instr_rdata_o, data_rdata_o, expRd, winD ? "data" : "instr"); end
                checks++; if ({data_err_o, ram_en_o} !== {expErr, 1'b0}) begin fails++; $display("[TB] FAIL rnd_err c%0d: got err %b en %b, expected err %b en 0", c, data_err_o, ram_en_o, expErr); end
                if (winD) dPend = 0; else iPend = 0;
                busy = 0;
            end else if (iPend || dPend) begin
                winD    = dPend && (!iPend || !lastD);
                addr    = winD ? dAddr : iAddr;
                inRange = legal(addr);
                checks++; if (ram_en_o !== inRange) begin fails++; $display("[TB] FAIL rnd_en c%0d: got %b, expected %b", c, ram_en_o, inRange); end
                if (inRange) begin
                    checks++; if (ram_addr_o !== addr[AW+1:2]) begin fails++; $display("[TB] FAIL rnd_addr c%0d: got %0d, expected %0d", c, ram_addr_o, addr / 4); end
                    checks++; if ({ram_we_o, ram_be_o} !== (winD ? {dWe, dBe} : 5'b0)) begin fails++; $display("[TB] FAIL rnd_webe c%0d: got %b, expected %b", c, {ram_we_o, ram_be_o}, winD ? {dWe, dBe} : 5'b0); end
                end
                checks++; if ({instr_ack_o, data_ack_o} !== 2'b00) begin fails++; $display("[TB] FAIL rnd_grant_ack c%0d: got %b, expected 00", c, {instr_ack_o, data_ack_o}); end
                expRd  = (inRange && !(winD && dWe)) ? refMem[addr / 4] : 32'h0;
                expErr = winD && !inRange;
                if (winD && dWe && inRange) model_store(int'(addr / 4), dBe, dWdata);
                lastD = winD;
                busy  = 1;
            end else begin
                checks++; if ({ram_en_o, instr_ack_o, data_ack_o, data_err_o} !== 4'b0) begin fails++; $display("[TB] FAIL rnd_idle c%0d: got %b, expected 0000", c, {ram_en_o, instr_ack_o, data_ack_o, data_err_o}); end
            end
        end
        quiet_inputs();
    endtask

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) refMem[i] = init_word(i);
        rst_i = 1'b1;
        quiet_inputs();
        test_reset();
        test_single_fetch();
        test_byte_store_load();
        test_out_of_range();
        test_contention();
        test_reset_mid();
        test_idle();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
